// File: rtl/mips789_irq_pkg.sv
// mips789_irq_pkg: shared state encoding, default vector layout and status word field offsets for the interrupt responder.
package mips789_irq_pkg;
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_PEND = 2'd1,
    IRQ_SERV = 2'd2,
    IRQ_RSVD = 2'd3
  } irq_state_e;
  localparam logic [31:0] IRQ_VEC_BASE_DEF   = 32'h0000_0050;
  localparam logic [31:0] IRQ_VEC_STRIDE_DEF = 32'd8;
  localparam int STAT_STATE_LSB = 0;
  localparam int STAT_ID_LSB    = 4;
  localparam int STAT_PEND_LSB  = 8;
endpackage

// File: rtl/irq_pri_enc.sv
// irq_pri_enc: fixed-priority encoder, lowest set index wins.
module irq_pri_enc #(
  parameter int N = 4
) (
  input  logic [N-1:0] req_i,
  output logic         valid_o,
  output logic [2:0]   idx_o
);
  always_comb begin
    valid_o = |req_i;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req_i[i]) idx_o = 3'(i);
  end
endmodule

// File: rtl/irq_ctl.sv
// irq_ctl: masks and prioritises sticky requests, raises irq_o, supplies the handler vector and pulses the winner's clear on ack.
module irq_ctl
  import mips789_irq_pkg::*;
#(
  parameter int          N_SRC      = 4,
  parameter logic [31:0] VEC_BASE   = IRQ_VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = IRQ_VEC_STRIDE_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [N_SRC-1:0] irq_req,
  output logic [N_SRC-1:0] src_clr,
  input  logic [31:0]      din,
  input  logic             ld_mask,
  output logic             irq_o,
  input  logic             irq_ack,
  input  logic             eret,
  output logic [31:0]      vec_o,
  output logic [31:0]      stat_o
);
  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] mask_q, mask_d, src_clr_q, src_clr_d, pend;
  logic [2:0]       cur_id_q, cur_id_d, win_id;
  logic             win_v;
  logic             unused_din;
  assign unused_din = ^din[31:N_SRC];
  assign pend = irq_req & mask_q;
  irq_pri_enc #(.N(N_SRC)) u_pri (
    .req_i  (pend),
    .valid_o(win_v),
    .idx_o  (win_id)
  );
  always_comb begin
    state_d = state_q;
    cur_id_d = cur_id_q;
    src_clr_d = '0;
    mask_d = ld_mask ? din[N_SRC-1:0] : mask_q;
    case (state_q)
      IRQ_IDLE: if (win_v) begin
        state_d = IRQ_PEND;
        cur_id_d = win_id;
      end
      IRQ_PEND: if (irq_ack) begin
        state_d = IRQ_SERV;
        src_clr_d = N_SRC'(1) << cur_id_q;
      end
      IRQ_SERV: state_d = eret ? IRQ_IDLE : IRQ_SERV;
      default: state_d = IRQ_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IRQ_IDLE;
      mask_q <= '0;
      cur_id_q <= '0;
      src_clr_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      cur_id_q <= cur_id_d;
      src_clr_q <= src_clr_d;
    end
  end
  assign src_clr = src_clr_q;
  assign irq_o = state_q == IRQ_PEND;
  assign vec_o = VEC_BASE + 32'(cur_id_q) * VEC_STRIDE;
  always_comb begin
    stat_o = '0;
    stat_o[STAT_STATE_LSB +: 2] = state_q;
    stat_o[STAT_ID_LSB +: 3] = cur_id_q;
    stat_o[STAT_PEND_LSB +: 8] = 8'(pend);
  end
endmodule

// File: doc/irq_ctl.md
# irq_ctl

Interrupt responder for the peripheral request lines (timer `tmr_req` and similar sticky request latches). Masks and prioritises up to `N_SRC` sticky requests, raises a single level request to the CPU, and supplies a handler vector. On CPU acknowledge it emits a one-cycle clear pulse back to the winning source's latch, closing the request/clear handshake. It then blocks further interrupts until the CPU signals return-from-exception.

## Interface
Parameters:
- `N_SRC`, 4: number of request inputs (1..8).
- `VEC_BASE`, 32'h0000_0050: handler vector for source 0.
- `VEC_STRIDE`, 8: byte distance between consecutive source vectors.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `clr` in 1: reset, synchronous, active-high.
- `irq_req` in N_SRC: sticky request levels from the sources; bit i = source i.
- `src_clr` out N_SRC: one-cycle clear pulse to source latch i (drives that source's `clr`).
- `din` in 32: mask write data; bits [N_SRC-1:0] are used.
- `ld_mask` in 1: load `mask <= din[N_SRC-1:0]`.
- `irq_o` out 1: interrupt request to the CPU.
- `irq_ack` in 1: CPU has taken the exception (one-cycle pulse).
- `eret` in 1: CPU has returned from the handler (one-cycle pulse).
- `vec_o` out 32: handler address for the current source.
- `stat_o` out 32: status word {16'b0, pend[7:0], 1'b0, cur_id[2:0], 2'b0, state[1:0]}; unused `pend` bits are 0.

## Operation
- `pend = irq_req & mask`. Priority is fixed; the lowest index wins.
- States:
  - IDLE=0: if `pend != 0`, latch the winner into `cur_id` and go to PEND.
  - PEND=1: `irq_o=1`. On `irq_ack`, pulse `src_clr[cur_id]` and go to SERVICE.
  - SERVICE=2: on `eret`, go to IDLE.
- Encoding 3 is unused. If reached, the next state is IDLE.
- `irq_o` = (state==PEND), decoded from the state register.
- `vec_o = VEC_BASE + cur_id*VEC_STRIDE`, 32-bit, wraps modulo 2^32. It is valid whenever the state is PEND or SERVICE.
- Once in PEND the selection is committed. Later mask writes, or a higher-priority request arriving, do not change `cur_id` until the next IDLE evaluation.
- `irq_ack` outside PEND and `eret` outside SERVICE are ignored. No state change, no pulse.
- Requests arriving during PEND or SERVICE stay latched at the source and are evaluated on return to IDLE. There is no nesting.
- `ld_mask` is accepted in every state.
- Reset (`clr`), including mid-operation:
  - state=IDLE, `mask`=0 (all sources masked), `cur_id`=0.
  - `src_clr`=0, `irq_o`=0, `vec_o`=VEC_BASE, `stat_o`=0.
  - An in-flight `src_clr` pulse is suppressed.

## Timing
- Request visible (`pend != 0`) in IDLE at edge T → state=PEND and `irq_o`=1 after edge T. Latency is 1 cycle.
- `irq_ack` sampled high at edge A in PEND → after A: `src_clr[cur_id]`=1 for exactly one cycle, `irq_o`=0, state=SERVICE.
- The source latch clears at edge A+1, so `irq_req[i]` is low after A+1.
- `eret` at edge E in SERVICE → IDLE after E. If a request is still pending, PEND follows after E+1.
- Minimum interval between consecutive `irq_o` assertions is 2 cycles after `eret`.
- `ld_mask` and the IDLE evaluation on the same edge: selection uses the old mask; the new mask applies from the next edge.
- `clr` and `irq_ack` on the same edge: reset wins and no `src_clr` pulse is issued.
- `src_clr` is registered, never combinational from `irq_ack`.

## Structure
- Shared package `mips789_irq_pkg`:
  - state constants `IRQ_IDLE`, `IRQ_PEND`, `IRQ_SERV`;
  - default `VEC_BASE` and `VEC_STRIDE`;
  - the `stat_o` field offsets.
- One sub-module, `irq_pri_enc`: combinational priority encoder, N_SRC-bit input → {valid, 3-bit index}, lowest index wins. Its only instance is inside `irq_ctl`.
- Top block holds the FSM, mask register, `cur_id` register, `src_clr` pulse register, vector adder and status packing.

## Test plan
- Reset, then `irq_req`=4'b0001 with mask=0 → `irq_o` stays 0 for 10 cycles; `stat_o`=0.
- Mask=4'b1111, `irq_req`=4'b0001 → `irq_o`=1 one cycle later and `vec_o`=0x50. Ack → `src_clr`=4'b0001 for 1 cycle, `irq_o`=0. `eret` → IDLE.
- Mask=4'b1111, `irq_req`=4'b1010 → `cur_id`=1, `vec_o`=0x58, `src_clr`=4'b0010 on ack. After `eret` with bit 3 still set → `cur_id`=3, `vec_o`=0x68.
- In PEND for id 2, raise `irq_req[0]` and write mask=0 → `cur_id` stays 2 and ack clears bit 2 only. After `eret` nothing fires because the mask is 0.
- `irq_ack` pulses in IDLE and SERVICE, `eret` in PEND → no state change and no `src_clr` pulse.
- Assert `clr` on the same edge as `irq_ack` in PEND → after the edge: IDLE, `irq_o`=0, `src_clr`=0, mask=0.
